setup_capture: RTL and testbench
================================

SETUP_CAPTURE -- requirements
Module: setup_capture

Interface
REQ-001 Parameter SW_W, default 8: switch bus width.
REQ-002 Parameter LVL_W, default 2: level field width, taken from sw[LVL_W-1:0].
REQ-003 Parameter SEQ_W, default 2: sequence-select field width, taken from sw[LVL_W+SEQ_W-1:LVL_W].
REQ-004 Parameter MAX_LVL, default 3: highest legal level; larger values are clamped.
REQ-005 Parameter EDGE_MODE, default 1: 1 = capture on rising edge of E; 0 = capture whenever E is high (legacy behaviour).
REQ-006 clk  in  1  system clock; all state updates on rising edge.
REQ-007 R  in  1  reset, synchronous, active-high.
REQ-008 E  in  1  capture request from the game controller in the Setup state.
REQ-009 clr  in  1  unlock request; drops valid and re-arms capture.
REQ-010 sw  in  SW_W  raw switch inputs.
REQ-011 setup  out  SW_W  registered raw copy of sw at the last accepted capture.
REQ-012 level  out  LVL_W  registered, clamped level.
REQ-013 seq  out  SEQ_W  registered sequence-select field.
REQ-014 valid  out  1  high while a committed setup is held (LOCK state).
REQ-015 done  out  1  one-cycle pulse on commit.
REQ-016 err  out  1  one-cycle pulse, coincident with done, when the captured level exceeded MAX_LVL.

Function
REQ-017 FSM states IDLE, CAPT, CHECK, LOCK; one transition per clock edge at most.
REQ-018 Request = E & ~E_d when EDGE_MODE=1; request = E when EDGE_MODE=0; E_d is E delayed by one clock.
REQ-019 IDLE: on request at edge t0, sample sw into a shadow register and go to CAPT; otherwise stay.
REQ-020 CAPT: at edge t1, register clamped level = min(shadow level field, MAX_LVL) plus an over-range flag; go to CHECK.
REQ-021 CHECK: at edge t2, load setup, level, seq from shadow/clamp; set valid=1; go to LOCK.
REQ-022 done (and err if over-range) is high for exactly the cycle following t2; latency request-to-valid is 3 edges.
REQ-023 LOCK: E is ignored; outputs hold; clr=1 at an edge returns to IDLE with valid=0, setup/level/seq retained.
REQ-024 clr in CAPT or CHECK aborts to IDLE; outputs and valid unchanged, no done/err.
REQ-025 clr and request in the same IDLE cycle: clr wins, no capture; in EDGE_MODE=1 that edge is consumed.
REQ-026 After clr in EDGE_MODE=1, a new rising edge of E is needed; E held high does not recapture.
REQ-027 In EDGE_MODE=0, E held high causes recapture each time IDLE is re-entered.
REQ-028 Switch changes after t0 do not affect the committed values.
REQ-029 Level equal to MAX_LVL is legal (no err); MAX_LVL = 2^LVL_W-1 makes err unreachable.
REQ-030 Elaboration fails if SW_W < LVL_W+SEQ_W or MAX_LVL > 2^LVL_W-1.

Reset
REQ-031 R=1 at an edge, in any state, forces IDLE, setup=0, level=0, seq=0, valid=0, done=0, err=0, shadow=0.
REQ-032 E_d resets to 1, so E held high through reset produces no capture in EDGE_MODE=1.
REQ-033 R has priority over clr, E and every FSM transition.

Structure
REQ-034 Shared package setup_pkg holds the state encoding (IDLE=0, CAPT=1, CHECK=2, LOCK=3) and the default widths.
REQ-035 Rising-edge detection is one sub-module, rise_det (ports clk, R, d, q_rise, reset value of the delayed copy as parameter), reused by other input blocks.
REQ-036 All outputs come directly from registers; no combinational path from sw or E to any output.

Verification
REQ-037 Reset, then E pulse with sw=8'hB6 -> after 3 edges setup=8'hB6, level=2, seq=1, valid=1, done pulse 1 cycle, err=0.
REQ-038 MAX_LVL=2, sw=8'h07 captured -> level=2, seq=1, err and done pulse together, valid=1.
REQ-039 In LOCK, E toggled with sw=8'hFF -> outputs unchanged; then clr -> valid=0, setup still prior value, next E edge recaptures.
REQ-040 E held high through R deassertion (EDGE_MODE=1) -> no capture; EDGE_MODE=0 -> capture, valid after 3 edges.
REQ-041 clr asserted at t1 (CAPT) -> IDLE, no done, outputs unchanged; R asserted in LOCK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/setup_pkg.sv
// rtl/setup_pkg.sv - shared state encoding and default widths for setup capture
//
// Purpose : common typedefs and default parameter values for setup_capture
//           and the input blocks that reuse its conventions.
// Contents: state_t (IDLE=0, CAPT=1, CHECK=2, LOCK=3), *_DEF width defaults.
package setup_pkg;

    localparam int SW_W_DEF      = 8;
    localparam int LVL_W_DEF     = 2;
    localparam int SEQ_W_DEF     = 2;
    localparam int MAX_LVL_DEF   = 3;
    localparam int EDGE_MODE_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        CHECK = 2'd2,
        LOCK  = 2'd3
    } state_t;

endpackage

// File: rtl/rise_det.sv
// rtl/rise_det.sv - single-bit rising-edge detector with configurable reset history
//
// Purpose : q_rise is high in the cycle where d is high and was low one clock
//           earlier. RST_VAL sets the remembered history after reset; using 1
//           means a level held high through reset is not seen as an edge.
// Ports   : clk    in  system clock
//           R      in  synchronous active-high reset
//           d      in  level to watch
//           q_rise out rising-edge strobe (d & ~d delayed)
module rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic R,
    input  logic d,
    output logic q_rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (R) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign q_rise = d & ~d_q;

endmodule

// File: rtl/setup_capture.sv
// rtl/setup_capture.sv - switch setup capture FSM with level clamp and lock
//
// Purpose : samples the switch bus on a capture request, clamps the level
//           field, then commits setup/level/seq and holds them in LOCK until
//           clr re-arms capture.
// Ports   : clk   in  system clock
//           R     in  synchronous active-high reset
//           E     in  capture request
//           clr   in  unlock / abort request
//           sw    in  raw switch bus [SW_W-1:0]
//           setup out raw copy of sw at last accepted capture
//           level out clamped level field
//           seq   out sequence-select field
//           valid out high while a committed setup is held
//           done  out one-cycle commit pulse
//           err   out one-cycle pulse with done when the level was clamped
module setup_capture
    import setup_pkg::*;
#(
    parameter int SW_W      = SW_W_DEF,
    parameter int LVL_W     = LVL_W_DEF,
    parameter int SEQ_W     = SEQ_W_DEF,
    parameter int MAX_LVL   = MAX_LVL_DEF,
    parameter int EDGE_MODE = EDGE_MODE_DEF
) (
    input  logic             clk,
    input  logic             R,
    input  logic             E,
    input  logic             clr,
    input  logic [SW_W-1:0]  sw,
    output logic [SW_W-1:0]  setup,
    output logic [LVL_W-1:0] level,
    output logic [SEQ_W-1:0] seq,
    output logic             valid,
    output logic             done,
    output logic             err
);

    if (SW_W < LVL_W + SEQ_W || MAX_LVL > (1 << LVL_W) - 1) begin : g_param_check
        $error("setup_capture: illegal SW_W/LVL_W/SEQ_W/MAX_LVL combination");
    end

    localparam logic [LVL_W-1:0] MAX_L = LVL_W'(MAX_LVL);

    state_t            state;
    logic [SW_W-1:0]   shadow;
    logic [LVL_W-1:0]  lvl_c;
    logic              over;
    logic              e_rise;
    logic              req;
    logic [LVL_W-1:0]  shadow_lvl;

    // History resets to 1 so E already high when reset lifts is not an edge.
    rise_det #(.RST_VAL(1'b1)) u_rise (
        .clk    (clk),
        .R      (R),
        .d      (E),
        .q_rise (e_rise)
    );

    assign req        = (EDGE_MODE != 0) ? e_rise : E;
    assign shadow_lvl = shadow[LVL_W-1:0];

    always_ff @(posedge clk) begin
        if (R) begin
            state  <= IDLE;
            shadow <= '0;
            lvl_c  <= '0;
            over   <= 1'b0;
            setup  <= '0;
            level  <= '0;
            seq    <= '0;
            valid  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // clr beats a simultaneous request; the edge is still
                    // consumed because the detector history keeps tracking E.
                    if (!clr && req) begin
                        shadow <= sw;
                        state  <= CAPT;
                    end
                end
                CAPT: begin
                    if (clr) begin
                        state <= IDLE;
                    end else begin
                        over  <= (shadow_lvl > MAX_L);
                        lvl_c <= (shadow_lvl > MAX_L) ? MAX_L : shadow_lvl;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (clr) begin
                        state <= IDLE;
                    end else begin
                        setup <= shadow;
                        level <= lvl_c;
                        seq   <= shadow[LVL_W+SEQ_W-1:LVL_W];
                        valid <= 1'b1;
                        done  <= 1'b1;
                        err   <= over;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    // E is ignored here; committed values survive unlock.
                    if (clr) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_setup_capture.sv
// tb/tb_setup_capture.sv - directed vector bench for setup_capture
module tb_setup_capture;

    logic       clk = 1'b0;
    logic       R   = 1'b1;
    logic       e_a = 1'b0, clr_a = 1'b0;
    logic [7:0] sw_a = 8'h00;
    logic       e_b = 1'b0, clr_b = 1'b0;
    logic [7:0] sw_b = 8'h00;

    logic [7:0] setup_a, setup_b;
    logic [1:0] level_a, level_b, seq_a, seq_b;
    logic       valid_a, done_a, err_a, valid_b, done_b, err_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    setup_capture u_a (
        .clk(clk), .R(R), .E(e_a), .clr(clr_a), .sw(sw_a),
        .setup(setup_a), .level(level_a), .seq(seq_a),
        .valid(valid_a), .done(done_a), .err(err_a)
    );

    setup_capture #(.MAX_LVL(2), .EDGE_MODE(0)) u_b (
        .clk(clk), .R(R), .E(e_b), .clr(clr_b), .sw(sw_b),
        .setup(setup_b), .level(level_b), .seq(seq_b),
        .valid(valid_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic       e;
        logic       clr;
        logic [7:0] sw;
        logic [7:0] setup;
        logic [1:0] level;
        logic [1:0] seq;
        logic       valid;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vt[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] s, input logic [1:0] l,
                         input logic [1:0] q, input logic v, input logic d, input logic e);
        chk({tag, ".setup"}, 32'(setup_a), 32'(s));
        chk({tag, ".level"}, 32'(level_a), 32'(l));
        chk({tag, ".seq"},   32'(seq_a),   32'(q));
        chk({tag, ".valid"}, 32'(valid_a), 32'(v));
        chk({tag, ".done"},  32'(done_a),  32'(d));
        chk({tag, ".err"},   32'(err_a),   32'(e));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] s, input logic [1:0] l,
                         input logic [1:0] q, input logic v, input logic d, input logic e);
        chk({tag, ".setup"}, 32'(setup_b), 32'(s));
        chk({tag, ".level"}, 32'(level_b), 32'(l));
        chk({tag, ".seq"},   32'(seq_b),   32'(q));
        chk({tag, ".valid"}, 32'(valid_b), 32'(v));
        chk({tag, ".done"},  32'(done_b),  32'(d));
        chk({tag, ".err"},   32'(err_b),   32'(e));
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          e  clr sw     setup  lvl seq v  d  e
        vt[0]  = '{1, 0, 8'hB6, 8'h00, 0, 0, 0, 0, 0}; // t0
        vt[1]  = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0}; // t1, sw change ignored
        vt[2]  = '{0, 0, 8'h00, 8'hB6, 2, 1, 1, 1, 0}; // t2 commit
        vt[3]  = '{0, 0, 8'h00, 8'hB6, 2, 1, 1, 0, 0};
        vt[4]  = '{1, 0, 8'hFF, 8'hB6, 2, 1, 1, 0, 0}; // E ignored in LOCK
        vt[5]  = '{0, 0, 8'hFF, 8'hB6, 2, 1, 1, 0, 0};
        vt[6]  = '{1, 0, 8'hFF, 8'hB6, 2, 1, 1, 0, 0};
        vt[7]  = '{0, 1, 8'hFF, 8'hB6, 2, 1, 0, 0, 0}; // unlock, values kept
        vt[8]  = '{1, 0, 8'h3D, 8'hB6, 2, 1, 0, 0, 0}; // t0
        vt[9]  = '{0, 1, 8'h3D, 8'hB6, 2, 1, 0, 0, 0}; // clr at t1 aborts
        vt[10] = '{0, 0, 8'h3D, 8'hB6, 2, 1, 0, 0, 0};
        vt[11] = '{1, 0, 8'h3D, 8'hB6, 2, 1, 0, 0, 0}; // t0
        vt[12] = '{0, 0, 8'h3D, 8'hB6, 2, 1, 0, 0, 0};
        vt[13] = '{0, 0, 8'h3D, 8'h3D, 1, 3, 1, 1, 0}; // commit
        vt[14] = '{0, 0, 8'h3D, 8'h3D, 1, 3, 1, 0, 0};
        vt[15] = '{0, 1, 8'h3D, 8'h3D, 1, 3, 0, 0, 0}; // unlock
        vt[16] = '{1, 1, 8'hAA, 8'h3D, 1, 3, 0, 0, 0}; // clr wins, edge consumed
        vt[17] = '{1, 0, 8'hAA, 8'h3D, 1, 3, 0, 0, 0}; // held high: no capture
        vt[18] = '{1, 0, 8'hAA, 8'h3D, 1, 3, 0, 0, 0};
        vt[19] = '{1, 0, 8'hAA, 8'h3D, 1, 3, 0, 0, 0};
        vt[20] = '{0, 0, 8'hAA, 8'h3D, 1, 3, 0, 0, 0};
        vt[21] = '{1, 0, 8'h0F, 8'h3D, 1, 3, 0, 0, 0}; // t0, level = MAX_LVL
        vt[22] = '{0, 0, 8'h0F, 8'h3D, 1, 3, 0, 0, 0};
        vt[23] = '{0, 0, 8'h0F, 8'h0F, 3, 3, 1, 1, 0}; // legal at max, no err
        vt[24] = '{0, 0, 8'h0F, 8'h0F, 3, 3, 1, 0, 0};

        // Reset state of both instances.
        step();
        step();
        chk_a("reset_a", 8'h00, 0, 0, 0, 0, 0);
        chk_b("reset_b", 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        R = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            e_a   = vt[i].e;
            clr_a = vt[i].clr;
            sw_a  = vt[i].sw;
            step();
            chk_a($sformatf("vec%0d", i), vt[i].setup, vt[i].level, vt[i].seq,
                  vt[i].valid, vt[i].done, vt[i].err);
        end

        // Reset from LOCK, with E held high on both instances through reset.
        @(negedge clk);
        R = 1'b1; e_a = 1'b1; clr_a = 1'b0; e_b = 1'b1; sw_b = 8'h07;
        step();
        chk_a("lock_reset_a", 8'h00, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        R = 1'b0;

        // B (level-sensitive, MAX_LVL=2) captures; A (edge mode) must not.
        for (int k = 1; k <= 4; k++) begin
            step();
            chk(   $sformatf("held_a%0d.valid", k), 32'(valid_a), 32'd0);
            chk(   $sformatf("held_a%0d.done", k),  32'(done_a),  32'd0);
            if (k < 3)
                chk($sformatf("held_b%0d.valid", k), 32'(valid_b), 32'd0);
            else if (k == 3)
                chk_b("held_b3", 8'h07, 2, 1, 1, 1, 1);
            else
                chk_b("held_b4", 8'h07, 2, 1, 1, 0, 0);
            @(negedge clk);
        end

        // Unlock B with E still high; it recaptures on re-entering IDLE.
        clr_b = 1'b1; sw_b = 8'h06;
        step();
        chk_b("unlock_b", 8'h07, 2, 1, 0, 0, 0);
        @(negedge clk);
        clr_b = 1'b0;
        step();
        chk(  "recap_b_t0.valid", 32'(valid_b), 32'd0);
        step();
        chk(  "recap_b_t1.valid", 32'(valid_b), 32'd0);
        step();
        chk_b("recap_b_t2", 8'h06, 2, 1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
